decode_in_queue: RTL and testbench

- Parametrised instruction queue between the LC3 fetch stage and the decode stage; successor to the single-slot decode_in bus.
- Buffers up to DEPTH {npc, instruction, psr} tuples with valid/ready handshakes on both sides.
- Presents the head entry to decode and asserts enable_decode for each tuple decode consumes.
- Supports a single-cycle flush for branch/trap redirection.

---
 rtl/decode_in_queue.sv | 134 +++++++++++++
 tb/tb_decode_in_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_in_queue.sv
// decode_in_queue: instruction queue between the LC3 fetch and decode stages.
// Holds up to DEPTH {npc, instruction, psr} tuples in a circular buffer and
// presents the oldest one on registered head outputs with valid/ready
// handshakes on both sides. A synchronous flush empties the queue for
// branch/trap redirection.
//
// Optional feature: define DECODE_IN_QUEUE_OVF_CHK_EN to build a sticky
// overflow detector on err_overflow. Without it the port is tied to 0.
module decode_in_queue #(
  parameter int DATA_W = 16,
  parameter int PSR_W  = 3,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] npc_in,
  input  logic [DATA_W-1:0] Instr_dout,
  input  logic [PSR_W-1:0]  psr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] npc_out,
  output logic [DATA_W-1:0] instr_out,
  output logic [PSR_W-1:0]  psr_out,
  output logic              enable_decode,
  output logic [CNT_W-1:0]  count,
  output logic              err_overflow
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] npc;
    logic [DATA_W-1:0] instr;
    logic [PSR_W-1:0]  psr;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           in_entry;
  entry_t           head;
  entry_t           head_nxt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] remaining;
  logic             push;
  logic             pop;

  assign in_entry = '{npc: npc_in, instr: Instr_dout, psr: psr};

  // Full/empty gating comes straight from registered state, so neither
  // handshake has a combinational path from the other side.
  assign in_ready = (count != FULL_CNT);
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  // Entries left in the buffer after this cycle's pop, before any push.
  assign remaining = count - CNT_W'(pop);

  // Next-state for pointers, occupancy and the registered head entry.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; an unassigned path in always_comb infers a latch.
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    head_nxt   = head;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
      if (push && !pop)      count_nxt = count + CNT_W'(1);
      else if (pop && !push) count_nxt = count - CNT_W'(1);
      // The next head is either already in the buffer or is the tuple being
      // written right now (queue empty after this cycle's pop).
      if (count_nxt != '0) begin
        if (remaining == '0) head_nxt = in_entry;
        else                 head_nxt = mem[rd_ptr_nxt];
      end
    end
  end

  // Storage write; a flush discards the tuple offered in the same cycle.
  // NOTE: the buffer array has no reset: its contents are only observed
  // through count/pointers, which are reset, so clearing it buys nothing.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= in_entry;
  end

  // Control and head registers.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      out_valid     <= 1'b0;
      enable_decode <= 1'b0;
      head          <= '0;
    end else begin
      wr_ptr        <= wr_ptr_nxt;
      rd_ptr        <= rd_ptr_nxt;
      count         <= count_nxt;
      out_valid     <= (count_nxt != '0);
      enable_decode <= pop & ~flush;
      head          <= head_nxt;
    end
  end

  assign npc_out   = head.npc;
  assign instr_out = head.instr;
  assign psr_out   = head.psr;

`ifdef DECODE_IN_QUEUE_OVF_CHK_EN
  // Sticky overflow: fetch offered a tuple while full; only reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                             err_overflow <= 1'b0;
    else if (in_valid && !in_ready && !flush) err_overflow <= 1'b1;
  end
`else
  assign err_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_decode_in_queue.sv
// Directed testbench for decode_in_queue (DEPTH = 4). Inputs change one time
// unit after the rising edge; outputs are checked there as well.
module tb_decode_in_queue;

  localparam int DATA_W = 16;
  localparam int PSR_W  = 3;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

`ifdef DECODE_IN_QUEUE_OVF_CHK_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic              clock;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] npc_in;
  logic [DATA_W-1:0] Instr_dout;
  logic [PSR_W-1:0]  psr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] npc_out;
  logic [DATA_W-1:0] instr_out;
  logic [PSR_W-1:0]  psr_out;
  logic              enable_decode;
  logic [CNT_W-1:0]  count;
  logic              err_overflow;

  int tests_run = 0;
  int tests_failed = 0;

  decode_in_queue #(
    .DATA_W(DATA_W), .PSR_W(PSR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .npc_in(npc_in), .Instr_dout(Instr_dout), .psr(psr),
    .out_valid(out_valid), .out_ready(out_ready),
    .npc_out(npc_out), .instr_out(instr_out), .psr_out(psr_out),
    .enable_decode(enable_decode), .count(count), .err_overflow(err_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [15:0] npc_v, input logic [15:0] instr_v,
                       input logic [2:0] psr_v);
    in_valid   = 1'b1;
    npc_in     = npc_v;
    Instr_dout = instr_v;
    psr        = psr_v;
  endtask

  logic [15:0] exp_q[$];
  int          model_cnt;
  logic [15:0] next_instr;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    npc_in = '0; Instr_dout = '0; psr = '0;

    // Reset values
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_enable_decode", 32'(enable_decode), 0);
    check("rst_instr_out", 32'(instr_out), 0);
    check("rst_npc_out", 32'(npc_out), 0);
    check("rst_psr_out", 32'(psr_out), 0);
    check("rst_err_overflow", 32'(err_overflow), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Single push, then pop
    offer(16'h3001, 16'h1021, 3'b010);
    step();
    in_valid = 1'b0;
    check("t1_out_valid", 32'(out_valid), 1);
    check("t1_npc_out", 32'(npc_out), 32'h3001);
    check("t1_instr_out", 32'(instr_out), 32'h1021);
    check("t1_psr_out", 32'(psr_out), 32'b010);
    check("t1_count", 32'(count), 1);
    check("t1_enable_pre", 32'(enable_decode), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t1_enable_decode", 32'(enable_decode), 1);
    check("t1_count_after_pop", 32'(count), 0);
    check("t1_out_valid_after_pop", 32'(out_valid), 0);
    step();
    check("t1_enable_drop", 32'(enable_decode), 0);

    // Overfill with five pushes, then drain
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("t2_in_ready_%0d", i), 32'(in_ready), (i <= 4) ? 1 : 0);
      offer(16'h3000 + 16'(i), 16'(i), 3'(i));
      step();
    end
    in_valid = 1'b0;
    check("t2_count_full", 32'(count), 4);
    check("t2_in_ready_full", 32'(in_ready), 0);
    check("t2_err_overflow", 32'(err_overflow), 32'(EXP_OVF));
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t2_drain_valid_%0d", i), 32'(out_valid), 1);
      check($sformatf("t2_drain_instr_%0d", i), 32'(instr_out), 32'(i));
      check($sformatf("t2_drain_npc_%0d", i), 32'(npc_out), 32'h3000 + 32'(i));
      step();
    end
    out_ready = 1'b0;
    check("t2_empty_count", 32'(count), 0);
    check("t2_empty_valid", 32'(out_valid), 0);
    check("t2_last_enable", 32'(enable_decode), 1);

    // Full queue, push and pop offered every cycle; in_ready gates the push
    exp_q.delete();
    for (int i = 1; i <= 4; i++) begin
      offer(16'h0, 16'h0010 + 16'(i), 3'b001);
      exp_q.push_back(16'h0010 + 16'(i));
      step();
    end
    check("t3_count_full", 32'(count), 4);
    model_cnt  = 4;
    next_instr = 16'h0021;
    out_ready  = 1'b1;
    offer(16'h0, next_instr, 3'b100);
    for (int c = 0; c < 8; c++) begin
      check($sformatf("t3_in_ready_%0d", c), 32'(in_ready),
            (model_cnt != 4) ? 1 : 0);
      check($sformatf("t3_head_%0d", c), 32'(instr_out), 32'(exp_q[0]));
      if (model_cnt != 4) begin
        exp_q.push_back(next_instr);
        model_cnt++;
      end
      void'(exp_q.pop_front());
      model_cnt--;
      step();
      if (model_cnt != 4 && Instr_dout == next_instr && c > 0) begin
        next_instr = next_instr + 16'h1;
      end else if (c == 0) begin
        next_instr = next_instr;
      end
      Instr_dout = next_instr;
      check($sformatf("t3_count_%0d", c), 32'(count), 32'(model_cnt));
      check($sformatf("t3_enable_%0d", c), 32'(enable_decode), 1);
    end
    in_valid = 1'b0;
    while (exp_q.size() > 0) begin
      check("t3_drain_instr", 32'(instr_out), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      step();
    end
    out_ready = 1'b0;
    check("t3_drained_count", 32'(count), 0);
    check("t3_drained_valid", 32'(out_valid), 0);

    // Flush with three entries while push and pop are both offered
    for (int i = 1; i <= 3; i++) begin
      offer(16'h4000, 16'h0040 + 16'(i), 3'b010);
      step();
    end
    check("t4_count_pre", 32'(count), 3);
    offer(16'h4000, 16'h0044, 3'b010);
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("t4_count", 32'(count), 0);
    check("t4_out_valid", 32'(out_valid), 0);
    check("t4_enable_decode", 32'(enable_decode), 0);
    check("t4_in_ready", 32'(in_ready), 1);
    offer(16'h4100, 16'h5020, 3'b001);
    step();
    in_valid = 1'b0;
    check("t4_new_valid", 32'(out_valid), 1);
    check("t4_new_head", 32'(instr_out), 32'h5020);
    check("t4_new_count", 32'(count), 1);
    check("t4_err_sticky", 32'(err_overflow), 32'(EXP_OVF));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Asynchronous reset between edges with two entries held
    offer(16'h6001, 16'h0061, 3'b100);
    step();
    offer(16'h6002, 16'h0062, 3'b100);
    step();
    in_valid = 1'b0;
    check("t5_count_pre", 32'(count), 2);
    #2 reset = 1'b1;
    #1;
    check("t5_count", 32'(count), 0);
    check("t5_out_valid", 32'(out_valid), 0);
    check("t5_in_ready", 32'(in_ready), 1);
    check("t5_instr_out", 32'(instr_out), 0);
    check("t5_npc_out", 32'(npc_out), 0);
    check("t5_err_overflow", 32'(err_overflow), 0);
    #1 reset = 1'b0;
    offer(16'h7001, 16'h7000, 3'b010);
    step();
    in_valid = 1'b0;
    check("t5_push_valid", 32'(out_valid), 1);
    check("t5_push_head", 32'(instr_out), 32'h7000);
    check("t5_push_count", 32'(count), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Alternating pushes with decode always ready
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      if (j % 2 == 0) offer(16'h8000, 16'h0080 + 16'(j), 3'b001);
      else            in_valid = 1'b0;
      step();
      if (j % 2 == 0) begin
        check($sformatf("t6_valid_%0d", j), 32'(out_valid), 1);
        check($sformatf("t6_head_%0d", j), 32'(instr_out), 32'h0080 + 32'(j));
        check($sformatf("t6_count_%0d", j), 32'(count), 1);
      end else begin
        check($sformatf("t6_count_%0d", j), 32'(count), 0);
        check($sformatf("t6_enable_%0d", j), 32'(enable_decode), 1);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
